// File: rtl/plic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | plic_pkg                                                         |
// | Shared types and helpers for the PLIC target-context controller. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package plic_pkg;

   typedef enum logic [1:0] {
      GW_IDLE    = 2'd0,
      GW_PENDING = 2'd1,
      GW_CLAIMED = 2'd2
   } gw_state_e;

   localparam int NO_ID = 0;

   // ID 0 is reserved, so SRC_N sources need room for SRC_N+1 codes
   function automatic int id_w(input int src_n);
      return $clog2(src_n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/max_finder_recur.sv
`default_nettype none
// +------------------------------------------------------------------+
// | max_finder_recur                                                 |
// | Recursive max-tree; ties resolve toward the lower input index.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module max_finder_recur #(
   parameter int N     = 2,
   parameter int VAL_W = 8,
   parameter int PLD_W = 8
) (
   input  logic [N-1:0][VAL_W-1:0] i_vals,
   input  logic [N-1:0][PLD_W-1:0] i_plds,
   output logic [VAL_W-1:0]        o_val,
   output logic [PLD_W-1:0]        o_pld
);

   if (N == 1) begin : g_leaf
      assign o_val = i_vals[0];
      assign o_pld = i_plds[0];
   end else begin : g_split
      localparam int LO_N = N / 2;
      localparam int HI_N = N - LO_N;

      logic [VAL_W-1:0] w_lo_val;
      logic [VAL_W-1:0] w_hi_val;
      logic [PLD_W-1:0] w_lo_pld;
      logic [PLD_W-1:0] w_hi_pld;

      max_finder_recur #(.N(LO_N), .VAL_W(VAL_W), .PLD_W(PLD_W)) u_lo (
         .i_vals (i_vals[LO_N-1:0]),
         .i_plds (i_plds[LO_N-1:0]),
         .o_val  (w_lo_val),
         .o_pld  (w_lo_pld)
      );

      max_finder_recur #(.N(HI_N), .VAL_W(VAL_W), .PLD_W(PLD_W)) u_hi (
         .i_vals (i_vals[N-1:LO_N]),
         .i_plds (i_plds[N-1:LO_N]),
         .o_val  (w_hi_val),
         .o_pld  (w_hi_pld)
      );

      // Strict compare keeps the lower half on a tie
      assign o_val = (w_hi_val > w_lo_val) ? w_hi_val : w_lo_val;
      assign o_pld = (w_hi_val > w_lo_val) ? w_hi_pld : w_lo_pld;
   end

endmodule
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// +------------------------------------------------------------------+
// | plic_gateway                                                     |
// | Per-source level gateway: IDLE -> PENDING -> CLAIMED -> IDLE.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module plic_gateway
   import plic_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_irq,
   input  logic      i_claim_hit,
   input  logic      i_complete_hit,
   output logic      o_pending,
   output logic      o_pending_next,
   output gw_state_e o_state
);

   gw_state_e r_state;
   gw_state_e w_state_next;
   logic      r_pending;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         GW_IDLE:    if (i_irq)          w_state_next = GW_PENDING;
         GW_PENDING: if (i_claim_hit)    w_state_next = GW_CLAIMED;
         GW_CLAIMED: if (i_complete_hit) w_state_next = GW_IDLE;
         default:                        w_state_next = GW_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= GW_IDLE;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pending <= (w_state_next == GW_PENDING);
      end
   end

   assign o_pending      = r_pending;
   assign o_pending_next = (w_state_next == GW_PENDING);
   assign o_state        = r_state;

endmodule
`default_nettype wire

// File: rtl/plic_target_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | plic_target_ctrl                                                 |
// | Per-context claim/complete controller and best-source selector.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module plic_target_ctrl
   import plic_pkg::*;
#(
   parameter int SRC_N  = 31,
   parameter int PRIO_W = 3,
   parameter int ID_W   = id_w(SRC_N)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [SRC_N-1:0]            i_irq,
   input  logic [SRC_N-1:0][PRIO_W-1:0] i_prio,
   input  logic [SRC_N-1:0]            i_enable,
   input  logic [PRIO_W-1:0]           i_threshold,
   input  logic                        i_claim,
   input  logic                        i_complete,
   input  logic [ID_W-1:0]             i_complete_id,
   output logic [ID_W-1:0]             o_claim_id,
   output logic [SRC_N-1:0]            o_pending,
   output logic                        o_eip
);

   logic [SRC_N-1:0]             w_pend_next;
   logic [SRC_N-1:0]             w_claim_hit;
   logic [SRC_N-1:0]             w_complete_hit;
   logic [SRC_N-1:0][PRIO_W-1:0] w_cand_val;
   logic [SRC_N-1:0][ID_W-1:0]   w_cand_id;
   gw_state_e                    w_state [SRC_N];

   logic [PRIO_W-1:0] w_best_val;
   logic [ID_W-1:0]   w_best_pld;
   logic [ID_W-1:0]   w_best_id;

   logic [ID_W-1:0]   r_claim_id;
   logic [PRIO_W-1:0] r_best_prio;
   logic              r_eip;

   for (genvar k = 0; k < SRC_N; k++) begin : g_src
      assign w_claim_hit[k]    = i_claim && (r_best_prio != '0) &&
                                 (r_claim_id == ID_W'(k + 1));
      // Out-of-range or unclaimed complete IDs never match here
      assign w_complete_hit[k] = i_complete && (w_state[k] == GW_CLAIMED) &&
                                 (i_complete_id == ID_W'(k + 1));

      plic_gateway u_gw (
         .clk            (clk),
         .rst_n          (rst_n),
         .i_irq          (i_irq[k]),
         .i_claim_hit    (w_claim_hit[k]),
         .i_complete_hit (w_complete_hit[k]),
         .o_pending      (o_pending[k]),
         .o_pending_next (w_pend_next[k]),
         .o_state        (w_state[k])
      );

      assign w_cand_val[k] = (w_pend_next[k] && i_enable[k]) ? i_prio[k] : '0;
      assign w_cand_id[k]  = ID_W'(k + 1);
   end

   max_finder_recur #(.N(SRC_N), .VAL_W(PRIO_W), .PLD_W(ID_W)) u_max (
      .i_vals (w_cand_val),
      .i_plds (w_cand_id),
      .o_val  (w_best_val),
      .o_pld  (w_best_pld)
   );

   assign w_best_id = (w_best_val == '0) ? ID_W'(NO_ID) : w_best_pld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_claim_id  <= '0;
         r_best_prio <= '0;
         r_eip       <= 1'b0;
      end else begin
         r_claim_id  <= w_best_id;
         r_best_prio <= w_best_val;
         r_eip       <= (w_best_val > i_threshold);
      end
   end

   assign o_claim_id = r_claim_id;
   assign o_eip      = r_eip;

endmodule
`default_nettype wire

// File: tb/tb_plic_target_ctrl.sv
`default_nettype none
// Bench for plic_target_ctrl: directed scenarios plus random traffic,
// all compared against an abstract per-source reference model.
module tb_plic_target_ctrl;

   localparam int SRC_N  = 31;
   localparam int PRIO_W = 3;
   localparam int ID_W   = 5;

   logic                         clk;
   logic                         rst_n;
   logic [SRC_N-1:0]             irq;
   logic [SRC_N-1:0][PRIO_W-1:0] prio;
   logic [SRC_N-1:0]             en;
   logic [PRIO_W-1:0]            thr;
   logic                         claim;
   logic                         complete;
   logic [ID_W-1:0]              complete_id;
   logic [ID_W-1:0]              claim_id;
   logic [SRC_N-1:0]             pending;
   logic                         eip;

   plic_target_ctrl #(.SRC_N(SRC_N), .PRIO_W(PRIO_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_irq         (irq),
      .i_prio        (prio),
      .i_enable      (en),
      .i_threshold   (thr),
      .i_claim       (claim),
      .i_complete    (complete),
      .i_complete_id (complete_id),
      .o_claim_id    (claim_id),
      .o_pending     (pending),
      .o_eip         (eip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: 0 = waiting, 1 = pending, 2 = claimed
   int st [SRC_N];
   int exp_id;
   bit exp_eip;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [SRC_N-1:0] model_pending();
      logic [SRC_N-1:0] p = '0;
      for (int k = 0; k < SRC_N; k++) p[k] = (st[k] == 1);
      return p;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < SRC_N; k++) st[k] = 0;
      exp_id  = 0;
      exp_eip = 1'b0;
   endtask

   // Advance the model by one clock using the inputs presented at this edge
   task automatic model_step();
      int nst [SRC_N];
      int best_p;
      int best_id;
      for (int k = 0; k < SRC_N; k++) begin
         nst[k] = st[k];
         if (st[k] == 0 && irq[k]) nst[k] = 1;
         else if (st[k] == 1 && claim && exp_id == k + 1) nst[k] = 2;
         else if (st[k] == 2 && complete && int'(complete_id) == k + 1) nst[k] = 0;
      end
      best_p  = 0;
      best_id = 0;
      for (int k = 0; k < SRC_N; k++)
         if (nst[k] == 1 && en[k] && int'(prio[k]) > best_p) begin
            best_p  = int'(prio[k]);
            best_id = k + 1;
         end
      exp_id  = best_id;
      exp_eip = (best_p > int'(thr));
      for (int k = 0; k < SRC_N; k++) st[k] = nst[k];
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check("claim_id", 32'(claim_id), 32'(exp_id));
      check("eip", 32'(eip), 32'(exp_eip));
      check("pending", 32'(pending), 32'(model_pending()));
   endtask

   task automatic clear_inputs();
      irq = '0; prio = '0; en = '1; thr = '0;
      claim = 1'b0; complete = 1'b0; complete_id = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int pick;

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      model_reset();
      #2;
      do_reset();
      check("rst_claim_id", 32'(claim_id), 32'd0);
      check("rst_eip", 32'(eip), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      step();

      // Priority winner, then tie to lowest ID
      do_reset();
      prio[1] = 3'd5; prio[6] = 3'd6; irq[1] = 1'b1; irq[6] = 1'b1;
      step();
      check("prio_win_id", 32'(claim_id), 32'd7);
      check("prio_win_eip", 32'(eip), 32'd1);
      prio[1] = 3'd6;
      step();
      check("tie_low_id", 32'(claim_id), 32'd2);

      // Claim/complete round trip with irq held high
      do_reset();
      prio[3] = 3'd3; irq[3] = 1'b1;
      step();
      check("cc_pend_id", 32'(claim_id), 32'd4);
      claim = 1'b1;
      step();
      claim = 1'b0;
      check("cc_claimed_id", 32'(claim_id), 32'd0);
      check("cc_claimed_pend", 32'(pending[3]), 32'd0);
      step(); step();
      check("cc_no_repend", 32'(pending[3]), 32'd0);
      complete = 1'b1; complete_id = 5'd4;
      step();
      complete = 1'b0;
      check("cc_idle_pend", 32'(pending[3]), 32'd0);
      step();
      check("cc_repend", 32'(pending[3]), 32'd1);
      check("cc_repend_id", 32'(claim_id), 32'd4);

      // Back-to-back claims
      do_reset();
      prio[0] = 3'd2; prio[4] = 3'd7; irq[0] = 1'b1; irq[4] = 1'b1;
      step();
      irq = '0;
      check("b2b_first", 32'(claim_id), 32'd5);
      claim = 1'b1;
      step();
      check("b2b_second", 32'(claim_id), 32'd1);
      step();
      check("b2b_empty", 32'(claim_id), 32'd0);
      claim = 1'b0;
      step();

      // Threshold and enable
      do_reset();
      prio[5] = 3'd4; irq[5] = 1'b1; thr = 3'd4;
      step();
      check("thr_eq_id", 32'(claim_id), 32'd6);
      check("thr_eq_eip", 32'(eip), 32'd0);
      thr = 3'd3;
      step();
      check("thr_lt_eip", 32'(eip), 32'd1);
      en[5] = 1'b0;
      step();
      check("dis_id", 32'(claim_id), 32'd0);
      check("dis_pend", 32'(pending[5]), 32'd1);

      // Illegal completes, then simultaneous claim and complete
      do_reset();
      prio[8] = 3'd2; irq[8] = 1'b1; prio[2] = 3'd5; irq[2] = 1'b1;
      step();
      claim = 1'b1;
      step();
      claim = 1'b0;
      check("ill_next_id", 32'(claim_id), 32'd9);
      complete = 1'b1;
      complete_id = 5'd0;  step();
      complete_id = 5'd9;  step();
      complete_id = 5'd31; step();
      check("ill_pending", 32'(pending), 32'h0000_0100);
      claim = 1'b1; complete_id = 5'd3;
      step();
      claim = 1'b0; complete = 1'b0;
      check("both_pending", 32'(pending), 32'd0);
      step();
      check("both_repend", 32'(pending), 32'h0000_0004);

      // Async reset while source 3 is claimed
      do_reset();
      prio[2] = 3'd4; prio[0] = 3'd1; irq[2] = 1'b1; irq[0] = 1'b1;
      step();
      claim = 1'b1;
      step();
      claim = 1'b0;
      check("pre_rst_id", 32'(claim_id), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_claim_id", 32'(claim_id), 32'd0);
      check("async_eip", 32'(eip), 32'd0);
      check("async_pending", 32'(pending), 32'd0);
      do_reset();

      // Random traffic
      for (int k = 0; k < SRC_N; k++) prio[k] = PRIO_W'($urandom_range(0, 7));
      thr = PRIO_W'($urandom_range(0, 3));
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < SRC_N; k++)
            if ($urandom_range(0, 9) == 0) irq[k] = ~irq[k];
         if ($urandom_range(0, 7) == 0) prio[$urandom_range(0, SRC_N - 1)] = PRIO_W'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) en[$urandom_range(0, SRC_N - 1)] ^= 1'b1;
         if ($urandom_range(0, 31) == 0) thr = PRIO_W'($urandom_range(0, 7));
         claim    = ($urandom_range(0, 3) == 0);
         complete = ($urandom_range(0, 2) == 0);
         complete_id = ID_W'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) begin
            pick = $urandom_range(0, SRC_N - 1);
            for (int j = 0; j < SRC_N; j++)
               if (st[(pick + j) % SRC_N] == 2) begin
                  complete_id = ID_W'(((pick + j) % SRC_N) + 1);
                  break;
               end
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
